// File: rtl/apb_rw_scheduler.sv
// APB master sequencer for the AXI4-Lite bridge: round-robin write/read arbitration, one transfer in flight.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_rw_scheduler #(
  parameter int dataWidth      = 32,
  parameter int addrWidth      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req_valid,
  output logic                   wr_req_ready,
  input  logic [addrWidth-1:0]   wr_addr,
  input  logic [dataWidth-1:0]   wr_data,
  input  logic [dataWidth/8-1:0] wr_strb,
  input  logic [2:0]             wr_prot,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [addrWidth-1:0]   rd_addr,
  input  logic [2:0]             rd_prot,
  output logic                   wr_done_valid,
  input  logic                   wr_done_ready,
  output logic [1:0]             wr_resp,
  output logic                   rd_done_valid,
  input  logic                   rd_done_ready,
  output logic [dataWidth-1:0]   rd_data,
  output logic [1:0]             rd_resp,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [addrWidth-1:0]   paddr,
  output logic [dataWidth-1:0]   pwdata,
  output logic [dataWidth/8-1:0] pstrb,
  output logic [2:0]             pprot,
  input  logic [dataWidth-1:0]   prdata,
  input  logic                   pready,
  input  logic                   pslverr,
  output logic [1:0]             fsm_state
);

  localparam int STRB_W = dataWidth / 8;

  if ((dataWidth % 8) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("apb_rw_scheduler: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_wr_q;
  logic                cur_wr_q;
  logic [addrWidth-1:0] addr_q;
  logic [dataWidth-1:0] data_q;
  logic [STRB_W-1:0]   strb_q;
  logic [2:0]          prot_q;
  logic [1:0]          wr_resp_q, rd_resp_q;
  logic [dataWidth-1:0] rd_data_q;
  logic                grant_wr, grant_rd, accept, done_hs, timeout;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Request ready is only raised in IDLE for the granted side; done valid is only raised
  // in RESP and holds with stable resp/data until the matching done ready is seen.
  always_comb begin
    grant_wr = wr_req_valid && (!rd_req_valid || !last_wr_q);
    grant_rd = rd_req_valid && (!wr_req_valid ||  last_wr_q);
  end

  assign wr_req_ready = (state_q == IDLE) && !rst && grant_wr;
  assign rd_req_ready = (state_q == IDLE) && !rst && grant_rd;
  assign accept       = wr_req_ready || rd_req_ready;
  assign done_hs      = cur_wr_q ? wr_done_ready : rd_done_ready;

`ifdef APB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle; pready in that cycle still wins.
  assign timeout = (state_q == ACCESS) && !pready && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout) state_d = RESP;
      RESP:    if (done_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      cur_wr_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      wr_resp_q <= '0;
      rd_resp_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_wr_q <= grant_wr;
        cur_wr_q  <= grant_wr;
        addr_q    <= grant_wr ? wr_addr : rd_addr;
        data_q    <= grant_wr ? wr_data : '0;
        strb_q    <= grant_wr ? wr_strb : '0;
        prot_q    <= grant_wr ? wr_prot : rd_prot;
      end
      if (state_q == ACCESS && pready) begin
        if (cur_wr_q) begin
          wr_resp_q <= {pslverr, 1'b0};
        end else begin
          rd_resp_q <= {pslverr, 1'b0};
          rd_data_q <= pslverr ? '0 : prdata;
        end
      end else if (timeout) begin
        if (cur_wr_q) begin
          wr_resp_q <= 2'b10;
        end else begin
          rd_resp_q <= 2'b10;
          rd_data_q <= '0;
        end
      end
    end
  end

  assign psel          = (state_q == SETUP) || (state_q == ACCESS);
  assign penable       = (state_q == ACCESS);
  assign pwrite        = psel && cur_wr_q;
  assign paddr         = addr_q;
  assign pwdata        = data_q;
  assign pstrb         = strb_q;
  assign pprot         = prot_q;
  assign wr_done_valid = (state_q == RESP) &&  cur_wr_q;
  assign rd_done_valid = (state_q == RESP) && !cur_wr_q;
  assign wr_resp       = wr_resp_q;
  assign rd_resp       = rd_resp_q;
  assign rd_data       = rd_data_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_apb_rw_scheduler.sv
// Bench for apb_rw_scheduler: directed scenarios plus randomized transfers against a transaction-level model.
module tb_apb_rw_scheduler;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
  logic [AW-1:0] wr_addr, rd_addr, paddr;
  logic [DW-1:0] wr_data, rd_data, pwdata, prdata;
  logic [SW-1:0] wr_strb, pstrb;
  logic [2:0]    wr_prot, rd_prot, pprot;
  logic          wr_done_valid, wr_done_ready, rd_done_valid, rd_done_ready;
  logic [1:0]    wr_resp, rd_resp, fsm_state;
  logic          psel, penable, pwrite, pready, pslverr;

  apb_rw_scheduler #(.dataWidth(DW), .addrWidth(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_prot(wr_prot),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr(rd_addr), .rd_prot(rd_prot),
    .wr_done_valid(wr_done_valid), .wr_done_ready(wr_done_ready), .wr_resp(wr_resp),
    .rd_done_valid(rd_done_valid), .rd_done_ready(rd_done_ready),
    .rd_data(rd_data), .rd_resp(rd_resp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: last grant side (1 = write) and last completed read value.
  bit            last_w;
  logic [DW-1:0] model_rd;
  logic [DW+1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    last_w = 1'b0;
    model_rd = '0;
  endtask

  // One full transfer starting in an IDLE cycle with the request valids already driven.
  task automatic xfer(input int waits, input bit err, input logic [DW-1:0] rdat,
                      input int hold, input bit keep, output bit granted_w);
    bit            exp_w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [2:0]    ep;
    logic [1:0]    er;
    logic [DW+1:0] exp_done;
    if (wr_req_valid && rd_req_valid) exp_w = !last_w;
    else exp_w = wr_req_valid;
    ea = exp_w ? wr_addr : rd_addr;
    ed = exp_w ? wr_data : '0;
    es = exp_w ? wr_strb : '0;
    ep = exp_w ? wr_prot : rd_prot;
    @(negedge clk);
    granted_w = wr_req_ready;
    check_eq("wr_req_ready_idle", wr_req_ready, exp_w);
    check_eq("rd_req_ready_idle", rd_req_ready, !exp_w);
    check_eq("psel_idle", psel, 1'b0);
    cyc();
    last_w = exp_w;
    if (!keep) begin
      if (exp_w) wr_req_valid = 1'b0;
      else rd_req_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("setup_sel_en", {psel, penable}, 2'b10);
    check_eq("setup_pwrite", pwrite, exp_w);
    check_eq("setup_paddr", paddr, ea);
    check_eq("setup_pwdata", pwdata, ed);
    check_eq("setup_pstrb", pstrb, es);
    check_eq("setup_pprot", pprot, ep);
    check_eq("setup_req_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    cyc();
    for (int i = 0; i < waits; i++) begin
      pready = 1'b0;
      pslverr = 1'($urandom);
      prdata = $urandom;
      @(negedge clk);
      check_eq("wait_sel_en", {psel, penable}, 2'b11);
      check_eq("wait_fields", {pwrite, paddr, pstrb}, {exp_w, ea, es});
      check_eq("wait_pwdata", pwdata, ed);
      check_eq("wait_done", {wr_done_valid, rd_done_valid, wr_req_ready, rd_req_ready}, 4'b0);
      cyc();
    end
    pready = 1'b1;
    pslverr = err;
    prdata = rdat;
    @(negedge clk);
    check_eq("access_sel_en", {psel, penable}, 2'b11);
    er = err ? 2'b10 : 2'b00;
    if (!exp_w) model_rd = err ? '0 : rdat;
    exp_q.push_back({er, model_rd});
    cyc();
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = $urandom;
    exp_done = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (exp_w) begin
        wr_done_ready = (h == hold);
        rd_done_ready = 1'($urandom);
      end else begin
        rd_done_ready = (h == hold);
        wr_done_ready = 1'($urandom);
      end
      @(negedge clk);
      check_eq("resp_sel_en", {psel, penable}, 2'b00);
      check_eq("resp_done_valid", {wr_done_valid, rd_done_valid}, {exp_w, !exp_w});
      if (exp_w) check_eq("wr_resp", wr_resp, exp_done[DW+1:DW]);
      else check_eq("rd_resp", rd_resp, exp_done[DW+1:DW]);
      check_eq("rd_data", rd_data, exp_done[DW-1:0]);
      check_eq("resp_req_ready", {wr_req_ready, rd_req_ready}, 2'b00);
      cyc();
    end
    wr_done_ready = 1'b0;
    rd_done_ready = 1'b0;
    check_eq("done_drop", {wr_done_valid, rd_done_valid}, 2'b00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gw;
    int n_acc;
    bit seen;
    rst = 1'b1;
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    wr_addr = '0; wr_data = '0; wr_strb = '0; wr_prot = '0;
    rd_addr = '0; rd_prot = '0;
    wr_done_ready = 1'b0; rd_done_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    last_w = 1'b0; model_rd = '0;
    repeat (3) cyc();
    @(negedge clk);
    check_eq("rst_req_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    check_eq("rst_apb_ctrl", {psel, penable, pwrite}, 3'b000);
    check_eq("rst_apb_bus", {paddr, pstrb, pprot}, '0);
    check_eq("rst_pwdata", pwdata, '0);
    check_eq("rst_done", {wr_done_valid, rd_done_valid, wr_resp, rd_resp}, '0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_state", fsm_state, 2'd0);
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // Write only, zero-wait slave
    wr_req_valid = 1'b1; wr_addr = 32'h10; wr_data = 32'hA5A5A5A5; wr_strb = 4'hF; wr_prot = 3'd0;
    xfer(0, 1'b0, 32'h0, 0, 1'b0, gw);
    // Read with three wait states
    rd_req_valid = 1'b1; rd_addr = 32'h20; rd_prot = 3'd2;
    xfer(3, 1'b0, 32'h12345678, 0, 1'b0, gw);
    check_eq("read_value", rd_data, 32'h12345678);
    // Write with SLVERR and held response while a read is pending
    wr_req_valid = 1'b1; wr_addr = 32'h44; wr_data = 32'h0BADF00D; wr_strb = 4'h3; wr_prot = 3'd1;
    rd_req_valid = 1'b1; rd_addr = 32'h48;
    xfer(1, 1'b1, 32'h0, 5, 1'b0, gw);
    check_eq("slverr_grant_w", gw, 1'b1);
    xfer(0, 1'b0, 32'hCAFE0001, 0, 1'b0, gw);
    check_eq("pending_read_grant", gw, 1'b0);

    // Fairness from reset with both sides continuously valid
    do_reset();
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom); wr_prot = 3'($urandom);
      rd_addr = $urandom; rd_prot = 3'($urandom);
      xfer(0, 1'b0, $urandom, 0, 1'b1, gw);
      check_eq("fair_order", gw, (i % 2) == 0);
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;

    // Reset while in ACCESS
    rd_req_valid = 1'b1; rd_addr = 32'h80;
    @(negedge clk);
    cyc();
    rd_req_valid = 1'b0;
    cyc();
    pready = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_access", {psel, penable}, 2'b11);
    rst = 1'b1;
    wr_req_valid = 1'b1;
    cyc();
    @(negedge clk);
    check_eq("midrst_sel_en", {psel, penable}, 2'b00);
    check_eq("midrst_state", fsm_state, 2'd0);
    check_eq("midrst_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    rst = 1'b0;
    wr_req_valid = 1'b0;
    last_w = 1'b0;
    model_rd = '0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (wr_done_valid || rd_done_valid) seen = 1'b1;
    end
    check_eq("midrst_no_done", seen, 1'b0);
    check_eq("midrst_rd_data", rd_data, '0);

    // Slave that never answers
    rd_req_valid = 1'b1; rd_addr = 32'h90;
    @(negedge clk);
    cyc();
    rd_req_valid = 1'b0;
    cyc();
    pready = 1'b0;
    n_acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_done_valid) begin
        seen = 1'b1;
        break;
      end
      if (penable) n_acc++;
      cyc();
    end
`ifdef APB_TIMEOUT_EN
    check_eq("timeout_seen", seen, 1'b1);
    check_eq("timeout_access_cycles", n_acc, TO);
    check_eq("timeout_resp", rd_resp, 2'b10);
    check_eq("timeout_rd_data", rd_data, '0);
    check_eq("timeout_sel_en", {psel, penable}, 2'b00);
    rd_done_ready = 1'b1;
    cyc();
    rd_done_ready = 1'b0;
    check_eq("timeout_done_drop", rd_done_valid, 1'b0);
`else
    check_eq("no_timeout_done", seen, 1'b0);
    check_eq("no_timeout_access_cycles", n_acc, 100);
`endif
    do_reset();

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (!wr_req_valid && $urandom_range(0, 1) == 1) begin
        wr_req_valid = 1'b1; wr_addr = $urandom; wr_data = $urandom;
        wr_strb = 4'($urandom); wr_prot = 3'($urandom);
      end
      if (!rd_req_valid && $urandom_range(0, 1) == 1) begin
        rd_req_valid = 1'b1; rd_addr = $urandom; rd_prot = 3'($urandom);
      end
      if (!wr_req_valid && !rd_req_valid) begin
        wr_req_valid = 1'b1; wr_addr = $urandom; wr_data = $urandom;
        wr_strb = 4'($urandom); wr_prot = 3'($urandom);
      end
      xfer($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom,
           $urandom_range(0, 2), 1'b0, gw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_rw_scheduler.md
Name: apb_rw_scheduler

Overview:
- Sequences the APB master side of the AXI4-Lite to APB bridge.
- Accepts one write request (address, data, strobe) and one read request (address) from the bridge's AXI channel capture logic, and arbitrates between them round-robin.
- Runs the APB SETUP/ACCESS protocol for the granted request and returns the APB response to the originating channel.
- One transfer is outstanding at a time.

Parameters:
- dataWidth, 32, APB/AXI data width in bits; multiple of 8.
- addrWidth, 32, address width in bits.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined; range 1..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_req_valid  in  1  write request pending.
- wr_req_ready  out  1  write request accepted this cycle.
- wr_addr  in  addrWidth  write address.
- wr_data  in  dataWidth  write data.
- wr_strb  in  dataWidth/8  write byte strobes.
- wr_prot  in  3  write protection attributes.
- rd_req_valid  in  1  read request pending.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_addr  in  addrWidth  read address.
- rd_prot  in  3  read protection attributes.
- wr_done_valid  out  1  write response available.
- wr_done_ready  in  1  write response consumed.
- wr_resp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- rd_done_valid  out  1  read response available.
- rd_done_ready  in  1  read response consumed.
- rd_data  out  dataWidth  read data.
- rd_resp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- psel, penable, pwrite  out  1 each  APB control signals.
- paddr  out  addrWidth  APB address.
- pwdata  out  dataWidth  APB write data.
- pstrb  out  dataWidth/8  APB write strobes.
- pprot  out  3  APB protection attributes.
- prdata  in  dataWidth  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset:
  - rst is sampled on the clk edge.
  - All registered outputs go to 0; the FSM goes to IDLE; last_grant = READ, so a write wins the first tie.
  - While rst is high, wr_req_ready and rd_req_ready are 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - The grant is computed combinationally: if only one valid is high, that side is granted; if both are high, the side opposite last_grant is granted.
  - The granted *_req_ready is 1 in the same cycle. Request ready outputs are 0 in every other state.
  - When valid & ready, the request fields are captured, last_grant is updated, and the next state is SETUP.
- SETUP (exactly one cycle):
  - psel=1, penable=0.
  - paddr/pprot come from the captured request; pwrite=1 for a write.
  - For a write, pwdata/pstrb come from the captured request. For a read, pwdata=0 and pstrb=0.
  - Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1; all APB address/data/control outputs are held stable.
  - On pready=1: capture prdata (reads only) and resp = pslverr ? 2'b10 : 2'b00; drive psel=penable=0 in the next cycle; next state is RESP.
  - pslverr is ignored when pready=0.
- RESP:
  - The matching *_done_valid is 1, and resp/data are held stable until *_done_ready=1.
  - On the done handshake, *_done_valid drops in the next cycle and the next state is IDLE.
  - A new request can be accepted in that IDLE cycle.
- Latency:
  - Request accepted at cycle T: SETUP at T+1, ACCESS at T+2.
  - With pready=1 at T+2, done_valid is asserted at T+3.
  - Minimum request-to-request spacing is 4 cycles with zero-wait slaves.
- Fairness: with both requesters continuously valid, grants strictly alternate W, R, W, R...
- Reset mid-transfer: the next edge returns to IDLE with psel=penable=0. The in-flight transfer is dropped and no done_valid is produced.
- rd_data holds the last read value until the next read completes. It is 0 after reset, and 0 when a read completes with SLVERR.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle while pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the transfer is terminated: next state RESP, resp=2'b10, psel=penable=0, and rd_data is set to 0 for reads.
  - pready=1 in the same cycle as the limit wins: a normal completion.
- Not defined: no counter exists, and ACCESS waits indefinitely for pready.

Test Plan:
- Write only: wr_addr=0x10, wr_data=0xA5A5A5A5, wr_strb=4'hF, pready=1 on the first ACCESS cycle.
  - Expect psel at T+1, penable at T+2, pwrite=1, paddr=0x10, pwdata=0xA5A5A5A5, pstrb=4'hF.
  - Expect wr_done_valid=1 with wr_resp=00 at T+3.
- Read with waits: rd_addr=0x20, pready low for 3 ACCESS cycles, then prdata=0x12345678.
  - Expect pstrb=0 and pwrite=0, with APB signals stable through the waits.
  - Expect rd_data=0x12345678, rd_resp=00.
- Both valid continuously for 4 transfers from reset: expect grant order W, R, W, R, with exactly one ready pulse per grant.
- pslverr=1 with pready on a write: expect wr_resp=10. Hold wr_done_ready=0 for 5 cycles: expect wr_done_valid and wr_resp held, and rd_req_ready stays 0 throughout.
- rst asserted in ACCESS: expect psel=penable=0 and state IDLE after one edge, and no done_valid.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0: expect rd_done_valid after 16 ACCESS cycles with rd_resp=10 and rd_data=0. Without the macro, expect no response after 100 cycles.
